// File: rtl/writeback_queue.sv
// Register-file write-back stage: ALU results write directly, mult/div results go through a
// small FIFO. Handles write-after-write kills, ALU-vs-queue fairness, r0 suppression and forwarding.
module writeback_queue #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  rd_a,
  input  logic [4:0]  rd_b,
  output logic        fwd_valid_a,
  output logic        fwd_valid_b,
  output logic [31:0] fwd_data_a,
  output logic [31:0] fwd_data_b,
  output logic        ctrl_writeEn,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] q;
  logic [PW-1:0]      head, tail;
  logic [PW:0]        count;
  logic [WW-1:0]      wait_cnt;

  logic head_live, alu_wr, head_issue, pop, push;

  always_comb begin
    head_live  = (count != '0) && q[head].live;
    alu_stall  = head_live && (wait_cnt == WW'(MAX_WAIT));
    // ctrl_reset gates the ALU path so nothing reaches the write port while in reset.
    alu_wr     = ctrl_reset && alu_valid && !alu_stall && (alu_rd != 5'd0);
    head_issue = head_live && !alu_wr;
    // Dead heads drain regardless of ALU activity.
    pop        = (count != '0) && (!q[head].live || head_issue);
    md_ready   = (count < (PW+1)'(DEPTH));
    push       = md_valid && md_ready && (md_rd != 5'd0);
  end

  always_comb begin
    ctrl_writeEn  = 1'b0;
    ctrl_writeReg = 5'd0;
    data_writeReg = 32'd0;
    if (alu_wr) begin
      ctrl_writeEn  = 1'b1;
      ctrl_writeReg = alu_rd;
      data_writeReg = alu_data;
    end else if (head_issue) begin
      ctrl_writeEn  = 1'b1;
      ctrl_writeReg = q[head].rd;
      data_writeReg = q[head].data;
    end
  end

  // Scan oldest to youngest so the youngest live match wins; the write port overrides all.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    fwd_valid_a = 1'b0;
    fwd_data_a  = 32'd0;
    fwd_valid_b = 1'b0;
    fwd_data_b  = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (q[idx].live && q[idx].rd == rd_a) begin
        fwd_valid_a = 1'b1;
        fwd_data_a  = q[idx].data;
      end
      if (q[idx].live && q[idx].rd == rd_b) begin
        fwd_valid_b = 1'b1;
        fwd_data_b  = q[idx].data;
      end
    end
    if (ctrl_writeEn && ctrl_writeReg == rd_a) begin
      fwd_valid_a = 1'b1;
      fwd_data_a  = data_writeReg;
    end
    if (ctrl_writeEn && ctrl_writeReg == rd_b) begin
      fwd_valid_b = 1'b1;
      fwd_data_b  = data_writeReg;
    end
    if (rd_a == 5'd0) begin
      fwd_valid_a = 1'b0;
      fwd_data_a  = 32'd0;
    end
    if (rd_b == 5'd0) begin
      fwd_valid_b = 1'b0;
      fwd_data_b  = 32'd0;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      q        <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (alu_wr && q[i].rd == alu_rd) q[i].live <= 1'b0;
      if (pop) begin
        q[head].live <= 1'b0;
        head         <= head + PW'(1);
      end
      if (push) begin
        q[tail] <= '{live: !(alu_wr && md_rd == alu_rd), rd: md_rd, data: md_data};
        tail    <= tail + PW'(1);
      end
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      wait_cnt <= (head_live && !head_issue) ? wait_cnt + WW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue; a small register-file model observes the write port.
module tb_writeback_queue;
  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        alu_valid, md_valid;
  logic [4:0]  alu_rd, md_rd, rd_a, rd_b;
  logic [31:0] alu_data, md_data;
  logic        alu_stall, md_ready, fwd_valid_a, fwd_valid_b, ctrl_writeEn;
  logic [31:0] fwd_data_a, fwd_data_b, data_writeReg;
  logic [4:0]  ctrl_writeReg;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  logic [31:0] rf [32];

  writeback_queue #(.DEPTH(4), .MAX_WAIT(3)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .rd_a(rd_a), .rd_b(rd_b),
    .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ctrl_writeEn) begin
      rf[ctrl_writeReg] <= data_writeReg;
      wr_cnt            <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are settled 1ns later.
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    @(negedge clock);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    md_valid  = mv; md_rd  = mrd; md_data  = mdat;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  int exp_reg [14] = '{1, 2, 3, 4, 20, 5, 6, 7, 21, 8, 9, 22, 23, 24};

  initial begin
    int ai, mi, w0;
    logic [31:0] exp_d;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rd_a = 5'd0; rd_b = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;

    // Reset, with producers active to confirm outputs are gated.
    ctrl_reset = 1'b0;
    rd_a = 5'd5;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
      chk("rst_wen", ctrl_writeEn, 1'b0);
      chk("rst_wreg", ctrl_writeReg, 5'd0);
      chk("rst_wdata", data_writeReg, 32'd0);
      chk("rst_ready", md_ready, 1'b1);
      chk("rst_stall", alu_stall, 1'b0);
      chk("rst_fwdv", fwd_valid_a, 1'b0);
      chk("rst_fwdd", fwd_data_a, 32'd0);
    end
    @(negedge clock);
    ctrl_reset = 1'b1;
    alu_valid = 1'b0; md_valid = 1'b0;
    rd_a = 5'd0;
    for (int c = 0; c < 3; c++) begin
      idle();
      chk("idle_wen", ctrl_writeEn, 1'b0);
    end

    // Single mult/div result.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF);
    chk("md_ready0", md_ready, 1'b1);
    chk("md_wen_enq", ctrl_writeEn, 1'b0);
    rd_a = 5'd3;
    idle();
    chk("md_wen", ctrl_writeEn, 1'b1);
    chk("md_wreg", ctrl_writeReg, 5'd3);
    chk("md_wdata", data_writeReg, 32'hDEADBEEF);
    chk("md_fwd_v", fwd_valid_a, 1'b1);
    chk("md_fwd_d", fwd_data_a, 32'hDEADBEEF);
    idle();
    chk("md_wen_after", ctrl_writeEn, 1'b0);
    chk("rf_r3", rf[3], 32'hDEADBEEF);
    rd_a = 5'd0;

    // mult/div write to r0 must never reach the port.
    w0 = wr_cnt;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    chk("r0_ready", md_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      idle();
      chk("r0_wen", ctrl_writeEn, 1'b0);
    end
    chk("r0_wrcnt", wr_cnt, w0);

    // Fairness: ALU busy on r1..r9, five mult/div results r20..r24.
    ai = 1; mi = 0;
    for (int c = 0; c < 14; c++) begin
      drive(ai <= 9, 5'(ai), 32'h100 + ai, mi < 5, 5'(20 + mi), 32'hA0 + mi);
      chk($sformatf("fair_stall%0d", c), alu_stall, (c == 4 || c == 8));
      chk($sformatf("fair_ready%0d", c), md_ready, !(c == 4 || c == 6 || c == 7 || c == 8));
      exp_d = (exp_reg[c] >= 20) ? 32'hA0 + exp_reg[c] - 20 : 32'h100 + exp_reg[c];
      chk($sformatf("fair_wen%0d", c), ctrl_writeEn, 1'b1);
      chk($sformatf("fair_wreg%0d", c), ctrl_writeReg, exp_reg[c]);
      chk($sformatf("fair_wdata%0d", c), data_writeReg, exp_d);
      if (alu_valid && !alu_stall) ai++;
      if (md_valid && md_ready) mi++;
    end
    idle();
    chk("fair_drained", ctrl_writeEn, 1'b0);

    // Write-after-write kill: queued r7 superseded by ALU.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1111);
    w0 = wr_cnt;
    drive(1'b1, 5'd7, 32'h2222, 1'b0, 5'd0, 32'd0);
    chk("kill_wreg", ctrl_writeReg, 5'd7);
    chk("kill_wdata", data_writeReg, 32'h2222);
    idle();
    chk("kill_dead_wen", ctrl_writeEn, 1'b0);
    idle();
    chk("kill_rf7", rf[7], 32'h2222);
    chk("kill_wrcnt", wr_cnt, w0 + 1);

    // Forwarding priority.
    drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd7, 32'h1111);
    drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd7, 32'h3333);
    rd_a = 5'd7; rd_b = 5'd0;
    drive(1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 32'd0);
    chk("fwd_q_v", fwd_valid_a, 1'b1);
    chk("fwd_q_d", fwd_data_a, 32'h3333);
    chk("fwd_r0_v", fwd_valid_b, 1'b0);
    chk("fwd_q_stall", alu_stall, 1'b0);
    drive(1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 32'd0);
    chk("fwd_port_v", fwd_valid_a, 1'b1);
    chk("fwd_port_d", fwd_data_a, 32'h5555);
    idle();
    chk("fwd_dead_wen", ctrl_writeEn, 1'b0);
    chk("fwd_dead_v", fwd_valid_a, 1'b0);
    chk("fwd_dead_d", fwd_data_a, 32'd0);
    idle();
    chk("fwd_dead2_wen", ctrl_writeEn, 1'b0);
    idle();
    chk("fwd_rf7", rf[7], 32'h5555);

    // Reset mid-stream discards three live entries.
    drive(1'b1, 5'd10, 32'h20, 1'b1, 5'd15, 32'hF15);
    drive(1'b1, 5'd11, 32'h21, 1'b1, 5'd16, 32'hF16);
    drive(1'b1, 5'd12, 32'h22, 1'b1, 5'd17, 32'hF17);
    rd_a = 5'd15;
    @(negedge clock);
    alu_valid = 1'b0; md_valid = 1'b0;
    ctrl_reset = 1'b0;
    #1;
    w0 = wr_cnt;
    chk("mrst_wen", ctrl_writeEn, 1'b0);
    chk("mrst_wreg", ctrl_writeReg, 5'd0);
    chk("mrst_ready", md_ready, 1'b1);
    chk("mrst_fwd", fwd_valid_a, 1'b0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      idle();
      chk("mrst_post_wen", ctrl_writeEn, 1'b0);
    end
    chk("mrst_wrcnt", wr_cnt, w0);
    chk("mrst_rf15", rf[15], 32'd0);
    chk("mrst_rf17", rf[17], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-back stage directly upstream of the 32x32 register file; drives its write port (ctrl_writeEn, ctrl_writeReg, data_writeReg).
- Merges two result producers: the single-cycle ALU, which has direct priority, and the multi-cycle mult/div unit, whose results are buffered in a small FIFO.
- Enforces write-after-write ordering, fairness between the two producers, and r0 suppression.
- Provides forwarding of pending writes for two lookup addresses.

Parameters:
- DEPTH, 4, mult/div queue entries; power of 2, >= 2.
- MAX_WAIT, 3, cycles a valid queue head may be starved by the ALU before the ALU is stalled.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- ctrl_reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU write not accepted this cycle; producer holds valid/rd/data.
- md_valid  in  1  mult/div result present.
- md_rd  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- md_ready  out  1  queue can accept; transfer occurs when md_valid & md_ready.
- rd_a, rd_b  in  5 each  forwarding lookup addresses.
- fwd_valid_a, fwd_valid_b  out  1 each  pending write found for rd_a / rd_b.
- fwd_data_a, fwd_data_b  out  32 each  forwarded value.
- ctrl_writeEn  out  1  register file write enable.
- ctrl_writeReg  out  5  register file write address.
- data_writeReg  out  32  register file write data.

Behaviour:
- State: DEPTH-entry circular FIFO, each entry {live, rd, data}; head/tail pointers; occupancy count 0..DEPTH; wait counter 0..MAX_WAIT.
- Reset (ctrl_reset=0, asynchronous): FIFO emptied, live bits cleared, wait counter 0. While in reset: alu_stall=0, md_ready=1, fwd_valid_*=0, fwd_data_*=0, ctrl_writeEn=0, ctrl_writeReg=0, data_writeReg=0. Reset mid-operation discards all pending entries; none are written.
- md_ready = (count < DEPTH), derived from registered count. Killed entries still occupy slots until popped.
- md enqueue: on the posedge where md_valid & md_ready, the entry is written at tail. md_rd=0: handshake completes, nothing is enqueued.
- ALU accept = alu_valid & ~alu_stall.
- ALU accepted with alu_rd != 0:
  - ctrl_writeEn=1, ctrl_writeReg=alu_rd, data_writeReg=alu_data, combinationally in the same cycle.
  - The live bit of every queue entry with rd==alu_rd is cleared at the posedge (superseded).
  - An md result enqueued the same cycle with md_rd==alu_rd is enqueued with live=0.
- ALU accepted with alu_rd=0: ctrl_writeEn=0; nothing is killed.
- Queue head issue, when count>0 and the head is live:
  - Issues only if no ALU write is accepted this cycle: ctrl_writeEn=1 with the head's rd and data; the head pops at the posedge.
  - Mult/div latency: enqueued at edge N, earliest write-port cycle N..N+1, committed at edge N+1.
- Dead head (live=0): pops at the posedge regardless of ALU activity and issues nothing.
- Simultaneous pop and enqueue in one cycle is allowed; count stays unchanged. Pointers wrap modulo DEPTH.
- Fairness:
  - Wait counter increments each cycle a live head is present but not issued; it clears when the head issues or the queue empties.
  - alu_stall = (wait counter == MAX_WAIT) & live head present. In that cycle the head issues and the counter clears, so the stall lasts exactly one cycle.
- Forwarding (combinational, per port x):
  - rd_x=0 gives fwd_valid_x=0.
  - Otherwise the first match in this priority order wins: (1) the write currently driven on the write port, (2) the youngest live queue entry with matching rd.
  - No match gives fwd_valid_x=0 and fwd_data_x=0.
  - md inputs in their enqueue cycle are not forwarded.
- ctrl_writeReg and data_writeReg are 0 whenever ctrl_writeEn=0.

Test Plan:
- Hold ctrl_reset=0 for 2 cycles -> all outputs 0, md_ready=1. Release, idle 3 cycles -> ctrl_writeEn stays 0.
- md write r3=32'hDEADBEEF, ALU idle -> next cycle ctrl_writeEn=1, ctrl_writeReg=3. Register file reads r3 = DEADBEEF afterwards. md write to r0 -> no write ever issued.
- alu_valid held high (targets r1..r9), md sends 5 results -> md_ready=0 after 4 enqueues and the 5th is held. alu_stall pulses for one cycle every MAX_WAIT+1=4 cycles; each pulse issues one queue entry, in FIFO order.
- Queue holds r7=32'h1111; ALU writes r7=32'h2222 -> r7 reads 2222 finally, and the 1111 entry is popped without any write.
- Queue holds r7=1111 then r7=3333; rd_a=7 -> fwd_valid_a=1, fwd_data_a=3333. With ALU writing r7=5555 the same cycle -> fwd_data_a=5555. rd_b=0 -> fwd_valid_b=0.
- Queue holds 3 live entries; assert ctrl_reset mid-stream -> outputs 0 immediately, and after release no queued value reaches the register file.
